ones_comp_serial_alu: RTL and testbench

Parametrised, bit-serial ones' complement adder/subtractor with a start/done handshake. It computes A+B or A−B (A + ~B) in ones' complement, including the end-around-carry correction pass, one bit per clock. It also reports signed overflow and can optionally normalise negative zero. It is the area-lean, width-generic sequential successor to the team's fixed 4-bit combinational ones' complement subtractor, and sits behind any control FSM that issues one operation at a time.

---
 rtl/ones_comp_serial_alu_if.sv | 32 +++
 rtl/ones_comp_serial_alu.sv | 153 +++++++++++++++
 tb/tb_ones_comp_serial_alu.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ones_comp_serial_alu_if.sv
`default_nettype none
// ============================================================================
// Module      : ones_comp_serial_alu_if
// Description : Request/response bundle for the bit-serial ones' complement
//               adder/subtractor.
//               master : drives start/sub/a/b, observes busy/done/result/overflow
//               slave  : the ALU side of the same signals
// Revision    : 1.0 - initial release
// ============================================================================
interface ones_comp_serial_alu_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             overflow;

    modport master (
        output start, sub, a, b,
        input  busy, done, result, overflow
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, result, overflow
    );
endinterface
`default_nettype wire

// File: rtl/ones_comp_serial_alu.sv
`default_nettype none
// ============================================================================
// Module      : ones_comp_serial_alu
// Description : Bit-serial ones' complement A+B / A-B with end-around carry.
//               One bit per clock: WIDTH add steps, WIDTH end-around-carry
//               steps, then a single commit edge (latency 2*WIDTH+1).
// Ports       : clk    - rising-edge clock
//               rst_n  - asynchronous active-low reset
//               bus    - slave modport: start/sub/a/b in,
//                        busy/done/result/overflow out
// Parameters  : WIDTH     - operand width (>= 2)
//               NORM_ZERO - 1: an all-ones result (-0) is committed as +0
// Revision    : 1.0 - initial release
// ============================================================================
module ones_comp_serial_alu #(
    parameter int WIDTH     = 4,
    parameter bit NORM_ZERO = 1'b0
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    ones_comp_serial_alu_if.slave  bus
);
    localparam int               c_cnt_w = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_one  = c_cnt_w'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_EAC  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next_state;

    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [WIDTH-1:0]     r_s;
    logic                 r_carry;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_a_sign;
    logic                 r_b_sign;
    logic [WIDTH-1:0]     r_result;
    logic                 r_overflow;
    logic                 r_done;

    logic                 w_last;
    logic                 w_add_sum;
    logic                 w_add_carry;
    logic                 w_eac_sum;
    logic                 w_eac_carry;
    logic                 w_neg_zero;

    assign w_last = (r_cnt == c_last);

    // Full-adder for the main pass; half-adder for the correction pass.
    // In the correction pass the carry register first holds the end-around
    // carry and afterwards the ripple carry, so one register serves both.
    assign w_add_sum   = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_add_carry = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));
    assign w_eac_sum   = r_s[0] ^ r_carry;
    assign w_eac_carry = r_s[0] & r_carry;

    assign w_neg_zero  = NORM_ZERO && (&r_s);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next_state = S_ADD;
            S_ADD:   if (w_last)    w_next_state = S_EAC;
            S_EAC:   if (w_last)    w_next_state = S_FIN;
            S_FIN:                  w_next_state = S_IDLE;
            default:                w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Serial datapath and committed outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a        <= '0;
            r_b        <= '0;
            r_s        <= '0;
            r_carry    <= 1'b0;
            r_cnt      <= '0;
            r_a_sign   <= 1'b0;
            r_b_sign   <= 1'b0;
            r_result   <= '0;
            r_overflow <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a      <= bus.a;
                        r_b      <= bus.sub ? ~bus.b : bus.b;
                        r_carry  <= 1'b0;
                        r_cnt    <= '0;
                        // Signs are kept aside because the operand
                        // registers are shifted out during the add pass.
                        r_a_sign <= bus.a[WIDTH-1];
                        r_b_sign <= bus.sub ? ~bus.b[WIDTH-1] : bus.b[WIDTH-1];
                    end
                end
                S_ADD: begin
                    r_s     <= {w_add_sum, r_s[WIDTH-1:1]};
                    r_a     <= {1'b0, r_a[WIDTH-1:1]};
                    r_b     <= {1'b0, r_b[WIDTH-1:1]};
                    r_carry <= w_add_carry;
                    r_cnt   <= w_last ? '0 : r_cnt + c_one;
                end
                S_EAC: begin
                    // The carry out of the last step is dropped: the
                    // end-around correction can never carry out again.
                    r_s     <= {w_eac_sum, r_s[WIDTH-1:1]};
                    r_carry <= w_eac_carry;
                    r_cnt   <= w_last ? '0 : r_cnt + c_one;
                end
                S_FIN: begin
                    r_result   <= w_neg_zero ? '0 : r_s;
                    // Raw sign of the sum, before any -0 normalisation.
                    r_overflow <= (r_a_sign == r_b_sign) && (r_s[WIDTH-1] != r_a_sign);
                    r_done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = (r_state != S_IDLE);
    assign bus.done     = r_done;
    assign bus.result   = r_result;
    assign bus.overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ones_comp_serial_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_ones_comp_serial_alu
// Description : Self-checking bench for ones_comp_serial_alu. Three DUTs:
//               WIDTH=4 NORM_ZERO=0, WIDTH=4 NORM_ZERO=1 (shared stimulus)
//               and WIDTH=8. A transaction-level model derives results from
//               plain ones' complement arithmetic; directed vectors carry
//               hand-computed results and latencies.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ones_comp_serial_alu;
    logic clk;
    logic rst_n;

    int n_vec = 0;
    int n_err = 0;

    ones_comp_serial_alu_if #(.WIDTH(4)) bus4  ();
    ones_comp_serial_alu_if #(.WIDTH(4)) bus4n ();
    ones_comp_serial_alu_if #(.WIDTH(8)) bus8  ();

    ones_comp_serial_alu #(.WIDTH(4), .NORM_ZERO(1'b0)) u_dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4));
    ones_comp_serial_alu #(.WIDTH(4), .NORM_ZERO(1'b1)) u_dut4n (.clk(clk), .rst_n(rst_n), .bus(bus4n));
    ones_comp_serial_alu #(.WIDTH(8), .NORM_ZERO(1'b0)) u_dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Comparison helper
    // ------------------------------------------------------------------
    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Ones' complement arithmetic, from the number-system definition:
    // add as unsigned, fold any carry out of WIDTH bits back in.
    // ------------------------------------------------------------------
    function automatic void oc_op(input int w, input logic [7:0] a, input logic [7:0] b,
                                  input bit s, input bit nz,
                                  output logic [7:0] res, output bit ov);
        int unsigned mask, av, bop, raw;
        bit sa, sb, sr;
        mask = (32'd1 << w) - 32'd1;
        av   = 32'(a) & mask;
        bop  = s ? (~32'(b) & mask) : (32'(b) & mask);
        raw  = av + bop;
        if (raw > mask) raw = raw - mask;    // -2^w +1
        sa = bit'((av  >> (w - 1)) & 1);
        sb = bit'((bop >> (w - 1)) & 1);
        sr = bit'((raw >> (w - 1)) & 1);
        ov = (sa == sb) && (sr != sa);
        if (nz && raw == mask) raw = 0;
        res = raw[7:0];
    endfunction

    // ------------------------------------------------------------------
    // Transaction model: op accepted when idle, answer appears after
    // 2*WIDTH+1 edges, start ignored while an op is pending.
    // ------------------------------------------------------------------
    int         m4_cnt, m8_cnt;
    logic       m4_done, m8_done;
    logic [7:0] m4_res, m4_resn, m8_res;
    logic       m4_ov, m8_ov;
    logic [7:0] p4_res, p4_resn, p8_res;
    bit         p4_ov, p4n_ov, p8_ov;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m4_cnt <= 0; m4_done <= 1'b0; m4_res <= '0; m4_resn <= '0; m4_ov <= 1'b0;
        end else begin
            m4_done <= 1'b0;
            if (m4_cnt == 0) begin
                if (bus4.start) begin
                    oc_op(4, {4'b0, bus4.a}, {4'b0, bus4.b}, bus4.sub, 1'b0, p4_res, p4_ov);
                    oc_op(4, {4'b0, bus4.a}, {4'b0, bus4.b}, bus4.sub, 1'b1, p4_resn, p4n_ov);
                    m4_cnt <= 2 * 4 + 1;
                end
            end else begin
                m4_cnt <= m4_cnt - 1;
                if (m4_cnt == 1) begin
                    m4_res <= p4_res; m4_resn <= p4_resn; m4_ov <= p4_ov; m4_done <= 1'b1;
                end
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m8_cnt <= 0; m8_done <= 1'b0; m8_res <= '0; m8_ov <= 1'b0;
        end else begin
            m8_done <= 1'b0;
            if (m8_cnt == 0) begin
                if (bus8.start) begin
                    oc_op(8, bus8.a, bus8.b, bus8.sub, 1'b0, p8_res, p8_ov);
                    m8_cnt <= 2 * 8 + 1;
                end
            end else begin
                m8_cnt <= m8_cnt - 1;
                if (m8_cnt == 1) begin
                    m8_res <= p8_res; m8_ov <= p8_ov; m8_done <= 1'b1;
                end
            end
        end
    end

    // Every-cycle comparison against the model, 1 time unit after the edge.
    always @(posedge clk) begin
        #1;
        chk("busy4",  bus4.busy,      m4_cnt != 0);
        chk("done4",  bus4.done,      m4_done);
        chk("res4",   bus4.result,    m4_res);
        chk("ovf4",   bus4.overflow,  m4_ov);
        chk("busy4n", bus4n.busy,     m4_cnt != 0);
        chk("done4n", bus4n.done,     m4_done);
        chk("res4n",  bus4n.result,   m4_resn);
        chk("ovf4n",  bus4n.overflow, m4_ov);
        chk("busy8",  bus8.busy,      m8_cnt != 0);
        chk("done8",  bus8.done,      m8_done);
        chk("res8",   bus8.result,    m8_res);
        chk("ovf8",   bus8.overflow,  m8_ov);
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (drive on the falling edge)
    // ------------------------------------------------------------------
    task automatic set4(input bit st, input logic [3:0] a, input logic [3:0] b, input bit s);
        bus4.start  = st; bus4.a  = a; bus4.b  = b; bus4.sub  = s;
        bus4n.start = st; bus4n.a = a; bus4n.b = b; bus4n.sub = s;
    endtask

    // Waits for done, counting edges; lat enters as edges already elapsed.
    task automatic wait_done4(inout int lat);
        while (bus4.done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b, input bit s,
                        input logic [3:0] exp_r, input logic [3:0] exp_rn, input bit exp_ov);
        int lat;
        @(negedge clk); set4(1'b1, a, b, s);
        @(posedge clk);                      // start edge
        @(negedge clk); set4(1'b0, 4'h0, 4'h0, 1'b0);
        lat = 0;
        // busy must stay high through the 2W steps before the commit edge
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1; lat++;
            if (i == 0 || i == 7) chk("busy_hi4", bus4.busy, 1'b1);
        end
        wait_done4(lat);
        chk("lat4",   8'(lat),        8'd9);
        chk("lit4",   bus4.result,    exp_r);
        chk("lit4n",  bus4n.result,   exp_rn);
        chk("litov4", bus4.overflow,  exp_ov);
        chk("busy_lo4", bus4.busy,    1'b0);
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input bit s,
                        input logic [7:0] exp_r, input bit exp_ov);
        int lat;
        @(negedge clk); bus8.start = 1'b1; bus8.a = a; bus8.b = b; bus8.sub = s;
        @(posedge clk);
        @(negedge clk); bus8.start = 1'b0;
        lat = 0;
        while (bus8.done !== 1'b1 && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("lat8",   8'(lat),       8'd17);
        chk("lit8",   bus8.result,   exp_r);
        chk("litov8", bus8.overflow, exp_ov);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        int lat;
        rst_n = 1'b0;
        set4(1'b0, 4'h0, 4'h0, 1'b0);
        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.sub = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", bus4.busy, 1'b0);
        chk("rst_done", bus4.done, 1'b0);
        chk("rst_res",  bus4.result, 8'h0);
        chk("rst_ov",   bus8.overflow, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // a, b, sub, result(NZ=0), result(NZ=1), overflow -- back-to-back
        run4(4'b0101, 4'b0011, 1'b1, 4'b0010, 4'b0010, 1'b0);
        run4(4'b0011, 4'b0011, 1'b1, 4'b1111, 4'b0000, 1'b0);
        run4(4'b0111, 4'b0001, 1'b0, 4'b1000, 4'b1000, 1'b1);
        run4(4'b1110, 4'b1110, 1'b0, 4'b1101, 4'b1101, 1'b0);
        run4(4'b1000, 4'b0001, 1'b1, 4'b0111, 4'b0111, 1'b1);
        run4(4'b0010, 4'b0011, 1'b0, 4'b0101, 4'b0101, 1'b0);

        run8(8'h10, 8'h20, 1'b1, 8'hEF, 1'b0);
        run8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b1);

        // Start pulses at edges 3 and 6 of a busy op must be ignored.
        @(negedge clk); set4(1'b1, 4'b0101, 4'b0011, 1'b1);
        @(posedge clk);
        @(negedge clk); set4(1'b0, 4'h0, 4'h0, 1'b0);
        repeat (2) @(negedge clk);
        set4(1'b1, 4'b0111, 4'b0001, 1'b0);
        @(negedge clk); set4(1'b0, 4'h0, 4'h0, 1'b0);
        repeat (2) @(negedge clk);
        set4(1'b1, 4'b1110, 4'b1110, 1'b0);
        @(negedge clk); set4(1'b0, 4'h0, 4'h0, 1'b0);
        lat = 6;
        wait_done4(lat);
        chk("ign_lat", 8'(lat),       8'd9);
        chk("ign_res", bus4.result,   4'b0010);
        chk("ign_ov",  bus4.overflow, 1'b0);

        // Abort with reset during cycle 5 of an operation.
        @(negedge clk); set4(1'b1, 4'b0111, 4'b0001, 1'b0);
        @(posedge clk);
        @(negedge clk); set4(1'b0, 4'h0, 4'h0, 1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", bus4.busy,     1'b0);
        chk("abort_done", bus4.done,     1'b0);
        chk("abort_res",  bus4.result,   8'h0);
        chk("abort_ov",   bus4.overflow, 1'b0);
        chk("abort_resn", bus4n.result,  8'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            chk("no_done", bus4.done, 1'b0);
        end
        run4(4'b0101, 4'b0011, 1'b1, 4'b0010, 4'b0010, 1'b0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
